// File: rtl/nibble_reg_pkg.sv
// Shared types and constants for the nibble register loader.
package nibble_reg_pkg;

    localparam int NIB_W      = 4;
    localparam int BYTE_W     = 8;
    localparam int CHK_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NIB0 = 3'd1,
        CHK0 = 3'd2,
        NIB1 = 3'd3,
        CHK1 = 3'd4
    } state_t;

    // When first and msb_first agree, the upper nibble goes out.
    function automatic logic [NIB_W-1:0] pick_nibble(
        input logic [BYTE_W-1:0] b,
        input logic              first,
        input logic              msb_first
    );
        return (first == msb_first) ? b[BYTE_W-1:NIB_W] : b[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/nibble_hold_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module nibble_hold_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] count_val,
    output logic         expired
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start) begin
            count <= count_val;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/nibble_reg_loader.sv
// Writes accepted bytes to a 4-bit load/data register as two held nibbles.
// Define NIBBLE_REG_LOADER_READBACK_EN to add readback check states and rb_err.
module nibble_reg_loader
    import nibble_reg_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              load,
    output logic [NIB_W-1:0]  data_out,
    output logic              busy,
    output logic              done
`ifdef NIBBLE_REG_LOADER_READBACK_EN
    ,
    input  logic [BYTE_W-1:0] rb_data,
    output logic              rb_err
`endif
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
`ifdef NIBBLE_REG_LOADER_READBACK_EN
    localparam logic [CW-1:0] CHK_LOAD = CW'(CHK_CYCLES - 1);
`endif

    state_t            state;
    state_t            state_nx;
    logic [BYTE_W-1:0] byte_q;
    logic [BYTE_W-1:0] cur_byte;
    logic              accept;
    logic              start;
    logic              expired;
    logic [CW-1:0]     count_val;

    // Valid/ready: a byte transfers on a posedge where in_valid and in_ready are both high.
    assign in_ready = (state == IDLE) & rst_n;
    assign accept   = in_valid & in_ready;
    assign cur_byte = accept ? in_data : byte_q;

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = NIB0;
                    start    = 1'b1;
                end
            end
            NIB0: begin
                if (expired) begin
`ifdef NIBBLE_REG_LOADER_READBACK_EN
                    state_nx = CHK0;
`else
                    state_nx = NIB1;
`endif
                    start    = 1'b1;
                end
            end
`ifdef NIBBLE_REG_LOADER_READBACK_EN
            CHK0: begin
                if (expired) begin
                    state_nx = NIB1;
                    start    = 1'b1;
                end
            end
            CHK1: begin
                if (expired) begin
                    state_nx = IDLE;
                end
            end
`endif
            NIB1: begin
                if (expired) begin
`ifdef NIBBLE_REG_LOADER_READBACK_EN
                    state_nx = CHK1;
`else
                    state_nx = IDLE;
`endif
                    start    = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        count_val = HOLD_LOAD;
`ifdef NIBBLE_REG_LOADER_READBACK_EN
        if (state_nx == CHK0 || state_nx == CHK1) begin
            count_val = CHK_LOAD;
        end
`endif
    end

    nibble_hold_timer #(
        .W(CW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count_val (count_val),
        .expired   (expired)
    );

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_q   <= '0;
            load     <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                byte_q <= in_data;
            end
            load <= (state_nx == NIB0) || (state_nx == NIB1);
            busy <= (state_nx != IDLE);
            done <= (state != IDLE) && (state_nx == IDLE);
            if (state_nx == NIB0) begin
                data_out <= pick_nibble(cur_byte, 1'b1, MSB_FIRST);
            end else if (state_nx == NIB1) begin
                data_out <= pick_nibble(byte_q, 1'b0, MSB_FIRST);
            end
        end
    end

`ifdef NIBBLE_REG_LOADER_READBACK_EN
    // data_out still holds the nibble just written while in a check state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rb_err <= 1'b0;
        end else if ((state == CHK0 || state == CHK1) && expired
                     && (rb_data != {{(BYTE_W-NIB_W){1'b0}}, data_out})) begin
            rb_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nibble_reg_loader.sv
// Bench for nibble_reg_loader: two instances (high-first and low-first) share one stimulus.
module tb_nibble_reg_loader;

    localparam int H = 2;
`ifdef NIBBLE_REG_LOADER_READBACK_EN
    localparam int CK = 2;
`else
    localparam int CK = 0;
`endif
    localparam int LAST = 2*H + 2*CK + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_ready;
    logic [1:0] load;
    logic [1:0] busy;
    logic [1:0] done;
    logic [3:0] data_out [2];
`ifdef NIBBLE_REG_LOADER_READBACK_EN
    logic [7:0] rb_data [2];
    logic [1:0] rb_err;
    logic       force_chk0 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: phase = cycles since the byte was accepted (0 = idle).
    int         phase = 0;
    logic [7:0] mbyte = 8'h00;
    logic       last_acc = 1'b0;
    logic [3:0] last_nib [2] = '{4'h0, 4'h0};
    logic       err_m [2] = '{1'b0, 1'b0};
    logic [3:0] reg_q [2] = '{4'h0, 4'h0};

    always #5 clk = ~clk;

    nibble_reg_loader #(.HOLD_CYCLES(H), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .load(load[0]), .data_out(data_out[0]),
        .busy(busy[0]), .done(done[0])
`ifdef NIBBLE_REG_LOADER_READBACK_EN
        , .rb_data(rb_data[0]), .rb_err(rb_err[0])
`endif
    );

    nibble_reg_loader #(.HOLD_CYCLES(H), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .load(load[1]), .data_out(data_out[1]),
        .busy(busy[1]), .done(done[1])
`ifdef NIBBLE_REG_LOADER_READBACK_EN
        , .rb_data(rb_data[1]), .rb_err(rb_err[1])
`endif
    );

`ifdef NIBBLE_REG_LOADER_READBACK_EN
    assign rb_data[0] = (force_chk0 && phase >= H+1 && phase <= H+CK) ? 8'h0F : {4'h0, reg_q[0]};
    assign rb_data[1] = (force_chk0 && phase >= H+1 && phase <= H+CK) ? 8'h0F : {4'h0, reg_q[1]};
`endif

    // Instance 0 writes the high nibble first, instance 1 the low nibble first.
    function automatic logic [3:0] exp_nib(input int i, input bit first);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(mbyte / 16);
        lo = 4'(mbyte % 16);
        if (i == 0) return first ? hi : lo;
        return first ? lo : hi;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] e_do;
        logic       e_load;
        for (int i = 0; i < 2; i++) begin
            e_load = (phase >= 1 && phase <= H) || (phase >= H+CK+1 && phase <= 2*H+CK);
            if (phase >= 1 && phase <= H+CK)
                e_do = exp_nib(i, 1'b1);
            else if (phase >= H+CK+1 && phase <= 2*H+2*CK)
                e_do = exp_nib(i, 1'b0);
            else
                e_do = last_nib[i];
            last_nib[i] = e_do;
            chk($sformatf("load%0d@ph%0d", i, phase), {7'h0, load[i]}, {7'h0, e_load});
            chk($sformatf("data_out%0d@ph%0d", i, phase), {4'h0, data_out[i]}, {4'h0, e_do});
            chk($sformatf("busy%0d@ph%0d", i, phase), {7'h0, busy[i]},
                {7'h0, (phase >= 1 && phase < LAST)});
            chk($sformatf("done%0d@ph%0d", i, phase), {7'h0, done[i]}, {7'h0, (phase == LAST)});
            chk($sformatf("in_ready%0d@ph%0d", i, phase), {7'h0, in_ready[i]},
                {7'h0, ((phase == 0 || phase == LAST) && rst_n)});
`ifdef NIBBLE_REG_LOADER_READBACK_EN
            chk($sformatf("rb_err%0d@ph%0d", i, phase), {7'h0, rb_err[i]}, {7'h0, err_m[i]});
`endif
        end
    endtask

    // One clock: sample inputs before the edge, advance the model after it, then compare.
    task automatic tick();
        logic       s_valid;
        logic       s_rst;
        logic [7:0] s_data;
        logic [1:0] s_load;
        logic [3:0] s_do [2];
`ifdef NIBBLE_REG_LOADER_READBACK_EN
        logic [7:0] s_rb [2];
        s_rb[0] = rb_data[0];
        s_rb[1] = rb_data[1];
`endif
        s_valid = in_valid;
        s_rst   = rst_n;
        s_data  = in_data;
        s_load  = load;
        s_do[0] = data_out[0];
        s_do[1] = data_out[1];
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (s_load[i] === 1'b1) reg_q[i] = s_do[i];
        last_acc = 1'b0;
        if (!s_rst) begin
            phase = 0;
            for (int i = 0; i < 2; i++) begin
                last_nib[i] = 4'h0;
                err_m[i]    = 1'b0;
            end
        end else begin
`ifdef NIBBLE_REG_LOADER_READBACK_EN
            for (int i = 0; i < 2; i++) begin
                if (phase == H+CK && s_rb[i] !== {4'h0, exp_nib(i, 1'b1)}) err_m[i] = 1'b1;
                if (phase == 2*H+2*CK && s_rb[i] !== {4'h0, exp_nib(i, 1'b0)}) err_m[i] = 1'b1;
            end
`endif
            if ((phase == 0 || phase == LAST) && s_valid) begin
                phase    = 1;
                mbyte    = s_data;
                last_acc = 1'b1;
            end else if (phase == LAST) begin
                phase = 0;
            end else if (phase > 0) begin
                phase++;
            end
        end
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep);
        in_valid = 1'b1;
        in_data  = b;
        last_acc = 1'b0;
        for (int n = 0; n < 40 && !last_acc; n++) tick();
        chk($sformatf("accept_%h", b), {7'h0, last_acc}, 8'h01);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40 && phase != 0; n++) tick();
        chk("idle_reached", (phase == 0) ? 8'h01 : 8'h00, 8'h01);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset held three cycles, then released.
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // High/low nibble ordering on 0xA5, then 0x3C with register contents checked.
        send_byte(8'hA5, 1'b0);
        wait_idle();
        send_byte(8'h3C, 1'b0);
        wait_idle();
        chk("reg_msb_first", {4'h0, reg_q[0]}, 8'h0C);
        chk("reg_lsb_first", {4'h0, reg_q[1]}, 8'h03);

        // Back-to-back: 0x34 waits on in_valid and is taken in the done cycle of 0x12.
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        wait_idle();

        // Reset two cycles into 0xFF aborts it; 0x01 then completes.
        send_byte(8'hFF, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h01, 1'b0);
        wait_idle();

        // Random bytes with random gaps and junk data while idle.
        for (int k = 0; k < 40; k++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            send_byte(8'($urandom_range(0, 255)), keep);
            if (!keep) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    in_data = 8'($urandom_range(0, 255));
                    tick();
                end
            end
        end
        in_valid = 1'b0;
        wait_idle();
        tick();

`ifdef NIBBLE_REG_LOADER_READBACK_EN
        // Corrupted readback during CHK0 sets rb_err, which survives good bytes until reset.
        force_chk0 = 1'b1;
        send_byte(8'hA5, 1'b0);
        wait_idle();
        force_chk0 = 1'b0;
        send_byte(8'h5A, 1'b0);
        wait_idle();
        send_byte(8'h77, 1'b0);
        wait_idle();
        chk("rb_err_sticky", {7'h0, rb_err[0]}, 8'h01);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rb_err_cleared", {7'h0, rb_err[0]}, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
